// File: rtl/implication_drain.sv
// Implication FIFO consumer: pops {unit, implication} entries and applies them.
// Optional IMPL_DROP_CNT_EN adds a saturating count of discarded entries.
module implication_drain #(
    parameter int VAR_NUM = 8,
    parameter int IDX_W   = 3,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic               fifo_empty,
    input  logic [DATA_W-1:0]  fifo_dataout,
    output logic               fifo_read,
    output logic [VAR_NUM-1:0] assign_def,
    output logic [VAR_NUM-1:0] assign_val,
    output logic [CNT_W-1:0]   implied_cnt,
    output logic               busy,
    output logic               done,
    output logic               conflict,
    output logic [IDX_W-1:0]   conflict_var
`ifdef IMPL_DROP_CNT_EN
    ,
    output logic [7:0]         drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_APPLY,
        S_DONE,
        S_CONFLICT
    } state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  entry_q;
    logic [VAR_NUM-1:0] def_q;
    logic [VAR_NUM-1:0] val_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               conf_q;
    logic [IDX_W-1:0]   cvar_q;
`ifdef IMPL_DROP_CNT_EN
    logic [7:0]         drop_q;
    logic [7:0]         drop_d;
`endif

    logic [IDX_W-1:0] ent_idx;
    logic             ent_unit;
    logic             ent_val;
    logic             unused_hi;

    assign ent_idx   = entry_q[IDX_W-1:0];
    assign ent_unit  = entry_q[IDX_W];
    assign ent_val   = entry_q[IDX_W+1];
    assign unused_hi = ^entry_q[DATA_W-1:IDX_W+2];

    // Pop only from FETCH and only when data exists.
    assign fifo_read    = (state_q == S_FETCH) && !fifo_empty;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign assign_def   = def_q;
    assign assign_val   = val_q;
    assign implied_cnt  = cnt_q;
    assign conflict     = conf_q;
    assign conflict_var = cvar_q;

`ifdef IMPL_DROP_CNT_EN
    assign drop_cnt = drop_q;
    assign drop_d   = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            def_q   <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            conf_q  <= 1'b0;
            cvar_q  <= '0;
`ifdef IMPL_DROP_CNT_EN
            drop_q  <= '0;
`endif
        end else if (clear) begin
            state_q <= S_IDLE;
            def_q   <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            conf_q  <= 1'b0;
            cvar_q  <= '0;
`ifdef IMPL_DROP_CNT_EN
            drop_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    state_q <= fifo_empty ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    entry_q <= fifo_dataout;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    state_q <= S_FETCH;
                    if (!ent_unit) begin
`ifdef IMPL_DROP_CNT_EN
                        drop_q <= drop_d;
`endif
                    end else if (!def_q[ent_idx]) begin
                        def_q[ent_idx] <= 1'b1;
                        val_q[ent_idx] <= ent_val;
                        cnt_q          <= cnt_q + 1'b1;
                    end else if (val_q[ent_idx] == ent_val) begin
`ifdef IMPL_DROP_CNT_EN
                        drop_q <= drop_d;
`endif
                    end else begin
                        conf_q  <= 1'b1;
                        cvar_q  <= ent_idx;
                        state_q <= S_CONFLICT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_CONFLICT: begin
                    state_q <= S_CONFLICT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_implication_drain.sv
// Directed bench for implication_drain with a FIFO model and a
// scoreboard of expected assignment state per popped entry.
module tb_implication_drain;

    logic       clock;
    logic       reset;
    logic       en;
    logic       clear;
    logic       fifo_empty;
    logic [7:0] fifo_dataout;
    logic       fifo_read;
    logic [7:0] assign_def;
    logic [7:0] assign_val;
    logic [3:0] implied_cnt;
    logic       busy;
    logic       done;
    logic       conflict;
    logic [2:0] conflict_var;
`ifdef IMPL_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    implication_drain dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .clear        (clear),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_read    (fifo_read),
        .assign_def   (assign_def),
        .assign_val   (assign_val),
        .implied_cnt  (implied_cnt),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .conflict_var (conflict_var)
`ifdef IMPL_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] def;
        logic [7:0] val;
        logic [3:0] cnt;
        logic       conf;
        logic [2:0] cv;
    } exp_t;

    logic [7:0] fq[$];
    exp_t       expq[$];

    logic [7:0] mdef;
    logic [7:0] mval;
    logic [3:0] mcnt;
    logic       mconf;
    logic [2:0] mcv;

    int n_cmp;
    int n_bad;
    int cycn;
    int cd;
    int npop;
    int ndone;
    int lastpop;
    int t0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdef  = '0;
        mval  = '0;
        mcnt  = '0;
        mconf = 1'b0;
        mcv   = '0;
        expq.delete();
        cd = 0;
    endtask

    // Queue an entry and push the state expected once it is applied.
    task automatic load(input logic [7:0] e);
        logic [2:0] idx;
        exp_t       x;
        fq.push_back(e);
        if (!mconf) begin
            idx = e[2:0];
            if (e[3]) begin
                if (!mdef[idx]) begin
                    mdef[idx] = 1'b1;
                    mval[idx] = e[4];
                    mcnt      = mcnt + 4'd1;
                end else if (mval[idx] != e[4]) begin
                    mconf = 1'b1;
                    mcv   = idx;
                end
            end
            x.def  = mdef;
            x.val  = mval;
            x.cnt  = mcnt;
            x.conf = mconf;
            x.cv   = mcv;
            expq.push_back(x);
        end
    endtask

    task automatic cyc();
        exp_t x;
        @(negedge clock);
        cycn++;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                chk("sb_avail", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    x = expq.pop_front();
                    chk("sb_entry",
                        32'({assign_def, assign_val, implied_cnt,
                             conflict, conflict_var}),
                        32'(x));
                end
            end
        end
        fifo_empty = (fq.size() == 0);
        if (done) ndone++;
        if (fifo_read) begin
            chk("rd_nonempty", 32'(fifo_empty), 32'd0);
            if (fq.size() != 0) fifo_dataout = fq.pop_front();
            npop++;
            if (lastpop >= 0) chk("pop_gap", 32'(cycn - lastpop), 32'd3);
            lastpop = cycn;
            cd = 3;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model_reset();
        fq.delete();
    endtask

    task automatic start_pass();
        lastpop = -1;
        en = 1'b1;
        cyc();
        en = 1'b0;
    endtask

    task automatic wait_done();
        t0 = ndone;
        for (int i = 0; i < 40 && ndone == t0; i++) cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cycn = 0;
        npop = 0;
        ndone = 0;
        lastpop = -1;
        reset = 1'b0;
        en = 1'b0;
        clear = 1'b0;
        fifo_empty = 1'b1;
        fifo_dataout = '0;
        model_reset();

        @(posedge clock);
        #1;
        chk("rst_outs",
            32'({fifo_read, assign_def, assign_val, implied_cnt,
                 busy, done, conflict, conflict_var}),
            32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc();
        chk("rst_idle", 32'(busy), 32'd0);

        // Empty pass
        start_pass();
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_done", 32'(done), 32'd0);
        cyc();
        chk("t1_done", 32'(done), 32'd1);
        cyc();
        chk("t1_after", 32'({busy, done}), 32'd0);
        chk("t1_npop", 32'(npop), 32'd0);
        chk("t1_def", 32'(assign_def), 32'h00);

        // Three implications
        npop = 0;
        load(8'h1D);
        load(8'h0A);
        load(8'h18);
        start_pass();
        wait_done();
        chk("t2_done_seen", 32'(ndone - t0), 32'd1);
        cyc();
        chk("t2_done_once", 32'(ndone - t0), 32'd1);
        chk("t2_npop", 32'(npop), 32'd3);
        chk("t2_def", 32'(assign_def), 32'h25);
        chk("t2_val", 32'(assign_val), 32'h21);
        chk("t2_cnt", 32'(implied_cnt), 32'd3);
        chk("t2_idle", 32'(busy), 32'd0);

        // Discards
        do_clear();
        chk("clr_def", 32'(assign_def), 32'h00);
        load(8'h05);
        load(8'h1D);
        load(8'h1D);
        start_pass();
        wait_done();
        cyc();
        chk("t3_def", 32'(assign_def), 32'h20);
        chk("t3_cnt", 32'(implied_cnt), 32'd1);
`ifdef IMPL_DROP_CNT_EN
        chk("t3_drop", 32'(drop_cnt), 32'd2);
`endif

        // Conflict
        do_clear();
        npop = 0;
        load(8'h1B);
        load(8'h0B);
        load(8'h1C);
        start_pass();
        t0 = ndone;
        for (int i = 0; i < 20; i++) cyc();
        chk("t4_conflict", 32'(conflict), 32'd1);
        chk("t4_cvar", 32'(conflict_var), 32'd3);
        chk("t4_val3", 32'(assign_val[3]), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_rd", 32'(fifo_read), 32'd0);
        chk("t4_npop", 32'(npop), 32'd2);
        chk("t4_pending", 32'(fq.size()), 32'd1);
        chk("t4_nodone", 32'(ndone - t0), 32'd0);

        // Clear during WAIT of the second entry
        do_clear();
        chk("t5_pre_conf", 32'(conflict), 32'd0);
        npop = 0;
        load(8'h1D);
        load(8'h0A);
        start_pass();
        repeat (4) cyc();
        chk("t5_first", 32'(assign_def), 32'h20);
        chk("t5_npop", 32'(npop), 32'd2);
        do_clear();
        chk("t5_clr",
            32'({busy, assign_def, assign_val, implied_cnt, conflict}),
            32'd0);
        repeat (4) cyc();
        chk("t5_dropped", 32'({assign_def, implied_cnt}), 32'd0);
        load(8'h18);
        start_pass();
        wait_done();
        cyc();
        chk("t5_fresh_done", 32'(ndone - t0), 32'd1);
        chk("t5_fresh_def", 32'(assign_def), 32'h01);
        chk("t5_fresh_cnt", 32'(implied_cnt), 32'd1);

        // Async reset during APPLY
        load(8'h1D);
        start_pass();
        cyc();
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async",
            32'({fifo_read, assign_def, assign_val, implied_cnt,
                 busy, done, conflict, conflict_var}),
            32'd0);
        model_reset();
        fq.delete();
        reset = 1'b1;
        cyc();
        chk("t6_idle", 32'(busy), 32'd0);
        cyc();
        chk("t6_stay", 32'({busy, assign_def}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
